blink_multi: RTL and testbench
==============================

# blink_multi

Multi-channel, run-time programmable LED blinker. Generalises the single-channel fixed-period blinker to NCH independent channels, each with its own period register, per-channel enable, and four output modes (off, on, blink, one-shot). Channels are programmed over a valid/ready config port. Sits between the board-control register block and the LED pins and is used as a formal-verification safety benchmark.

## Interface
- CBITS, 24: counter and period width per channel (≥1).
- NCH, 4: number of channels (1..16).
- CHW, $clog2(NCH) (min 1): width of the channel index.

- clk  in  1  single clock; all logic is on its rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  NCH  per-channel count enable.
- cfg_valid  in  1  config request.
- cfg_ready  out  1  config port can accept.
- cfg_ch  in  CHW  target channel.
- cfg_period  in  CBITS  terminal count P; the channel wraps every P+1 enabled cycles.
- cfg_mode  in  2  0=OFF, 1=ON, 2=BLINK, 3=ONESHOT.
- cfg_err  out  1  one-cycle pulse: accepted write had cfg_ch ≥ NCH.
- led  out  NCH  registered LED outputs.
- flg  out  NCH  registered one-cycle wrap pulse per channel.

## Operation
- Per-channel state: cnt[CBITS], period[CBITS], mode[2], phase[1].
- Reset (rst high at an edge):
  - cnt=0, phase=0, period=all ones, mode=BLINK.
  - led=0, flg=0, cfg_ready=0, cfg_err=0.
  - rst overrides any config write or count in the same cycle, including mid-period or mid-oneshot.
- cfg_ready:
  - Registered.
  - 1 in the first cycle after rst deasserts.
  - 0 for exactly one cycle after each accepted write, then 1 again.
- Accepted write = cfg_valid & cfg_ready at an edge.
  - cfg_ch < NCH: period←cfg_period, mode←cfg_mode, cnt←0, flg←0, phase←1 if cfg_mode=ONESHOT else 0. Overrides a wrap on that channel in the same cycle.
  - cfg_ch ≥ NCH: no state change; cfg_err=1 next cycle.
- Counting: at each edge with en[i]=1 and no write to channel i:
  - cnt≠period: cnt←cnt+1, flg←0.
  - cnt==period (wrap): cnt←0, flg←1, plus mode action:
    - BLINK: phase←~phase.
    - ONESHOT: phase←0, mode←OFF.
    - ON/OFF: phase unchanged.
- en[i]=0: cnt, phase and mode hold; flg←0.
- Width rule:
  - cnt never exceeds period; increment is modulo 2^CBITS.
  - P = all ones wraps after 2^CBITS cycles.
  - P = 0 wraps every enabled cycle.
- LED value, registered from next-state values, so led and flg change on the same edge:
  - OFF → 0.
  - ON → 1.
  - BLINK or ONESHOT → phase.
- Safety properties, per channel, each checked as an SVA assertion:
  - BLINK mode with led high in two consecutive cycles ⇒ flg low in the second cycle.
  - flg[i] is never high in two consecutive cycles unless P=0.
  - In BLINK mode, a change in led[i] implies flg[i]=1 in the same cycle.
  - cnt ≤ period always.

## Timing
- Write latency:
  - New mode and led are visible at the edge that accepts the write.
  - Counting resumes on the next edge.
- Counting after a write to period P with en held high:
  - First flg at the (P+1)th edge after the write edge.
  - Then every P+1 edges.
- Blink output period is 2(P+1) cycles at 50% duty.
- ONESHOT: led high for exactly P+1 cycles, then low, with flg high in the first low cycle.
- Write throughput: at most one write every 2 cycles.
- Writes to different channels never disturb each other's counters.

## Test plan
- Reset then defaults, CBITS=4, en=all 1:
  - led=0 immediately after reset.
  - First flg after 16 cycles, with led→1 on the same edge.
  - led toggles every 16 cycles; cfg_ready=1 one cycle after rst falls.
- Write ch1 P=2 BLINK:
  - led[1] pattern 0,0,0,1,1,1,… with flg[1] on each toggle edge.
  - cfg_ready low exactly one cycle after the write.
- Write ch2 P=3 ONESHOT:
  - led[2] high for 4 cycles, then flg[2]=1 and led[2]=0.
  - led[2] stays low; mode reads back OFF.
- Toggle en[0] low for 5 cycles mid-count at cnt=7:
  - No flg[0] while low.
  - Wrap occurs 5 cycles later than without the gap.
- Write with cfg_ch=NCH (non-power-of-2 NCH=3, cfg_ch=3):
  - cfg_err pulses once; no channel changes.
- Boundary cases:
  - Write to ch0 on the same edge it would wrap: write wins, flg[0]=0, cnt=0.
  - Assert rst during an ONESHOT: led→0 and mode→BLINK next cycle.
  - P=0 BLINK: led toggles every cycle with flg held high.

Source files
------------

// File: rtl/blink_multi.sv
// Multi-channel programmable LED blinker: NCH independent wrap counters, each
// with its own period and output mode, programmed through a valid/ready port.
module blink_multi #(
  parameter int CBITS = 24,
  parameter int NCH   = 4,
  parameter int CHW   = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NCH-1:0]     en,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [CHW-1:0]     cfg_ch,
  input  logic [CBITS-1:0]   cfg_period,
  input  logic [1:0]         cfg_mode,
  output logic               cfg_err,
  output logic [NCH-1:0]     led,
  output logic [NCH-1:0]     flg,
  output logic [2*NCH-1:0]   dbg_mode
);

  localparam logic [1:0] MODE_OFF     = 2'd0;
  localparam logic [1:0] MODE_ON      = 2'd1;
  localparam logic [1:0] MODE_BLINK   = 2'd2;
  localparam logic [1:0] MODE_ONESHOT = 2'd3;
  localparam logic [CHW:0] NCH_W = (CHW+1)'(NCH);

  logic [CBITS-1:0] cnt    [NCH];
  logic [CBITS-1:0] cnt_n  [NCH];
  logic [CBITS-1:0] period   [NCH];
  logic [CBITS-1:0] period_n [NCH];
  logic [1:0]       mode   [NCH];
  logic [1:0]       mode_n [NCH];
  logic [NCH-1:0]   phase, phase_n, led_n, flg_n, wr_sel;
  logic             wr, ch_ok;

  // Handshake: a write is taken at any edge where cfg_valid and cfg_ready are
  // both high; cfg_ready then drops for one cycle, so writes are >= 2 cycles apart.
  assign wr    = cfg_valid & cfg_ready;
  assign ch_ok = {1'b0, cfg_ch} < NCH_W;

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      wr_sel[i]   = wr && ch_ok && (cfg_ch == CHW'(i));
      cnt_n[i]    = cnt[i];
      period_n[i] = period[i];
      mode_n[i]   = mode[i];
      phase_n[i]  = phase[i];
      flg_n[i]    = 1'b0;
      if (wr_sel[i]) begin
        period_n[i] = cfg_period;
        mode_n[i]   = cfg_mode;
        cnt_n[i]    = '0;
        phase_n[i]  = (cfg_mode == MODE_ONESHOT);
      end else if (en[i]) begin
        if (cnt[i] == period[i]) begin
          cnt_n[i] = '0;
          flg_n[i] = 1'b1;
          if (mode[i] == MODE_BLINK) begin
            phase_n[i] = ~phase[i];
          end else if (mode[i] == MODE_ONESHOT) begin
            phase_n[i] = 1'b0;
            mode_n[i]  = MODE_OFF;
          end
        end else begin
          cnt_n[i] = cnt[i] + 1'b1;
        end
      end
      // LED follows next-state values so it moves on the same edge as flg.
      case (mode_n[i])
        MODE_OFF: led_n[i] = 1'b0;
        MODE_ON:  led_n[i] = 1'b1;
        default:  led_n[i] = phase_n[i];
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        cnt[i]    <= '0;
        period[i] <= '1;
        mode[i]   <= MODE_BLINK;
      end
      phase     <= '0;
      led       <= '0;
      flg       <= '0;
      cfg_ready <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        cnt[i]    <= cnt_n[i];
        period[i] <= period_n[i];
        mode[i]   <= mode_n[i];
      end
      phase     <= phase_n;
      led       <= led_n;
      flg       <= flg_n;
      cfg_ready <= ~wr;
      cfg_err   <= wr & ~ch_ok;
    end
  end

  always_comb begin
    dbg_mode = '0;
    for (int i = 0; i < NCH; i++) dbg_mode[2*i +: 2] = mode[i];
  end

  // Per-channel safety properties; cycles right after a reset or a write are excluded.
  for (genvar g = 0; g < NCH; g++) begin : g_sva
    a_blink_hold: assert property (@(posedge clk) disable iff (rst)
      (!$past(rst) && mode[g] == MODE_BLINK && led[g] && $past(led[g])) |-> !flg[g]);
    a_flg_single: assert property (@(posedge clk) disable iff (rst)
      (!$past(rst) && flg[g] && $past(flg[g])) |-> (period[g] == '0));
    a_blink_change: assert property (@(posedge clk) disable iff (rst)
      (!$past(rst) && !$past(wr_sel[g]) && mode[g] == MODE_BLINK && led[g] != $past(led[g]))
        |-> flg[g]);
    a_cnt_le: assert property (@(posedge clk) disable iff (rst) cnt[g] <= period[g]);
  end

endmodule

// File: tb/tb_blink_multi.sv
// Bench for blink_multi: an enabled-cycle-count model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_blink_multi;
  localparam int CBITS = 4;
  localparam int NCH   = 3;
  localparam int CHW   = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic [NCH-1:0]     en;
  logic               cfg_valid;
  logic               cfg_ready;
  logic [CHW-1:0]     cfg_ch;
  logic [CBITS-1:0]   cfg_period;
  logic [1:0]         cfg_mode;
  logic               cfg_err;
  logic [NCH-1:0]     led;
  logic [NCH-1:0]     flg;
  logic [2*NCH-1:0]   dbg_mode;

  int tests = 0;
  int fails = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  blink_multi #(.CBITS(CBITS), .NCH(NCH), .CHW(CHW)) dut (
    .clk(clk), .rst(rst), .en(en),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
    .cfg_period(cfg_period), .cfg_mode(cfg_mode), .cfg_err(cfg_err),
    .led(led), .flg(flg), .dbg_mode(dbg_mode)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- model ----------------
  // Each channel is described by the enabled cycles elapsed since its last
  // write (or reset); led, flg and mode follow from division by P+1.
  int       m_ecnt  [NCH];
  int       m_p     [NCH];
  logic [1:0] m_mode0 [NCH];
  bit       m_ph0   [NCH];
  bit       m_flg   [NCH];
  bit       m_ready, m_err, m_wr;
  bit       m_ok = 1'b0;

  function automatic int wraps(input int ch);
    return m_ecnt[ch] / (m_p[ch] + 1);
  endfunction

  function automatic logic exp_led(input int ch);
    case (m_mode0[ch])
      2'd0:    return 1'b0;
      2'd1:    return 1'b1;
      2'd2:    return m_ph0[ch] ^ (wraps(ch) % 2 == 1);
      default: return (wraps(ch) == 0);
    endcase
  endfunction

  function automatic logic [1:0] exp_mode(input int ch);
    if (m_mode0[ch] == 2'd3 && wraps(ch) > 0) return 2'd0;
    return m_mode0[ch];
  endfunction

  initial forever begin
    @(posedge clk);
    if (rst) begin
      for (int ch = 0; ch < NCH; ch++) begin
        m_ecnt[ch] = 0; m_p[ch] = 15; m_mode0[ch] = 2'd2; m_ph0[ch] = 0; m_flg[ch] = 0;
      end
      m_ready = 0; m_err = 0; m_ok = 1;
    end else begin
      m_wr  = cfg_valid && m_ready;
      m_err = m_wr && (cfg_ch >= NCH);
      for (int ch = 0; ch < NCH; ch++) begin
        if (m_wr && cfg_ch == ch) begin
          m_ecnt[ch] = 0; m_p[ch] = int'(cfg_period); m_mode0[ch] = cfg_mode;
          m_ph0[ch] = (cfg_mode == 2'd3); m_flg[ch] = 0;
        end else if (en[ch]) begin
          m_ecnt[ch]++;
          m_flg[ch] = (m_ecnt[ch] % (m_p[ch] + 1) == 0);
        end else begin
          m_flg[ch] = 0;
        end
      end
      m_ready = !m_wr;
    end
  end

  // ---------------- scoreboard / compare ----------------
  initial forever begin
    @(negedge clk);
    if (m_ok) begin
      for (int ch = 0; ch < NCH; ch++) begin
        check($sformatf("model_led[%0d]", ch), led[ch], exp_led(ch));
        check($sformatf("model_flg[%0d]", ch), flg[ch], m_flg[ch]);
        check($sformatf("model_mode[%0d]", ch), dbg_mode[2*ch +: 2], exp_mode(ch));
      end
      check("model_ready", cfg_ready, m_ready);
      check("model_err", cfg_err, m_err);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_write(input int ch, input int p, input int m);
    cfg_valid  = 1'b1;
    cfg_ch     = ch[CHW-1:0];
    cfg_period = p[CBITS-1:0];
    cfg_mode   = m[1:0];
    @(negedge clk);
    cfg_valid  = 1'b0;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    logic [6:0] blink_led;
    logic [6:0] blink_flg;
    blink_led = 7'b0111000;   // bit j = expected led[1] j cycles after the write
    blink_flg = 7'b1001000;
    rst = 1'b1; en = '1; cfg_valid = 1'b0; cfg_ch = '0; cfg_period = '0; cfg_mode = '0;
    step(2);
    check("rst_led", led, 3'b000);
    check("rst_ready", cfg_ready, 1'b0);
    check("rst_mode", dbg_mode, 6'b101010);
    rst = 1'b0;

    // Defaults: P=15 BLINK, first wrap on the 16th edge.
    for (int k = 1; k <= 32; k++) begin
      step(1);
      if (k == 1)  check("ready_after_rst", cfg_ready, 1'b1);
      if (k == 15) check("dflt_no_flg", flg, 3'b000);
      if (k == 16) begin check("dflt_flg16", flg, 3'b111); check("dflt_led16", led, 3'b111); end
      if (k == 31) check("dflt_led31", led, 3'b111);
      if (k == 32) begin check("dflt_led32", led, 3'b000); check("dflt_flg32", flg, 3'b111); end
    end

    // ch1 P=2 BLINK
    do_write(1, 2, 2);
    for (int j = 0; j < 7; j++) begin
      if (j > 0) step(1);
      check($sformatf("ch1_led_%0d", j), led[1], blink_led[j]);
      check($sformatf("ch1_flg_%0d", j), flg[1], blink_flg[j]);
      if (j == 0) check("ready_low_after_wr", cfg_ready, 1'b0);
      if (j == 1) check("ready_back", cfg_ready, 1'b1);
    end

    // ch2 P=3 ONESHOT
    do_write(2, 3, 3);
    for (int j = 0; j < 7; j++) begin
      if (j > 0) step(1);
      check($sformatf("os_led_%0d", j), led[2], (j < 4));
      check($sformatf("os_flg_%0d", j), flg[2], (j == 4));
      if (j == 0) check("os_mode_set", dbg_mode[5:4], 2'd3);
      if (j == 4) check("os_mode_off", dbg_mode[5:4], 2'd0);
    end

    // ch0 enable gap at cnt=7 delays the wrap by 5 cycles
    do_write(0, 15, 2);
    step(7);
    en[0] = 1'b0;
    for (int j = 1; j <= 5; j++) begin
      step(1);
      check($sformatf("gap_flg_%0d", j), flg[0], 1'b0);
    end
    en[0] = 1'b1;
    for (int j = 13; j <= 21; j++) begin
      step(1);
      check($sformatf("gap_wrap_%0d", j), flg[0], (j == 21));
      if (j == 20) check("gap_led20", led[0], 1'b0);
      if (j == 21) check("gap_led21", led[0], 1'b1);
    end

    // out-of-range channel
    do_write(3, 5, 1);
    check("err_pulse", cfg_err, 1'b1);
    check("err_ready", cfg_ready, 1'b0);
    check("err_modes", dbg_mode, 6'b001010);
    step(1);
    check("err_clear", cfg_err, 1'b0);

    // write lands on the wrap edge of ch0
    do_write(0, 3, 2);
    step(3);
    do_write(0, 5, 2);
    check("wwin_flg", flg[0], 1'b0);
    check("wwin_led", led[0], 1'b0);
    step(5);
    check("wwin_flg5", flg[0], 1'b0);
    step(1);
    check("wwin_flg6", flg[0], 1'b1);
    check("wwin_led6", led[0], 1'b1);

    // reset in the middle of a one-shot
    do_write(2, 7, 3);
    step(2);
    check("osr_led_pre", led[2], 1'b1);
    rst = 1'b1;
    step(1);
    check("osr_led", led, 3'b000);
    check("osr_mode", dbg_mode, 6'b101010);
    check("osr_flg", flg, 3'b000);
    check("osr_ready", cfg_ready, 1'b0);
    rst = 1'b0;
    step(1);
    check("osr_ready_back", cfg_ready, 1'b1);

    // P=0 BLINK: toggles every cycle with flg held high
    do_write(1, 0, 2);
    check("p0_led0", led[1], 1'b0);
    check("p0_flg0", flg[1], 1'b0);
    for (int j = 1; j <= 4; j++) begin
      step(1);
      check($sformatf("p0_led_%0d", j), led[1], (j % 2 == 1));
      check($sformatf("p0_flg_%0d", j), flg[1], 1'b1);
    end

    step(3);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
